// File: rtl/usb3_scramble_tx_pkg.sv
// usb3_scramble_tx_pkg: symbol constants, LFSR seed/taps, SKP defaults, word-source enum and lane helpers
package usb3_scramble_tx_pkg;
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h3C;
  localparam logic [15:0] LFSR_SEED = 16'hFFFF;
  localparam logic [15:0] LFSR_TAPS = 16'h0039;
  localparam int SKP_PERIOD_DEF = 354;
  localparam int SKP_OWED_MAX_DEF = 8;
  localparam logic [31:0] SKP_WORD = {4{K_SKP}};
  typedef enum logic [1:0] {SRC_IDLE, SRC_DATA, SRC_SKP} src_e;
  function automatic logic has_com(input logic [31:0] d, input logic [3:0] k);
    has_com = 1'b0;
    for (int i = 0; i < 4; i++) has_com = has_com || (k[i] && d[8*i +: 8] == K_COM);
  endfunction
  function automatic logic [31:0] d_mask(input logic [3:0] k);
    for (int i = 0; i < 4; i++) d_mask[8*i +: 8] = {8{!k[i]}};
  endfunction
endpackage

// File: rtl/usb3_scramble_tx_if.sv
// usb3_scramble_tx_if: upstream word handshake (in_*, in_ready) and PIPE-side output word (out_*); master = link side, slave = scrambler
interface usb3_scramble_tx_if;
  logic [31:0] in_data;
  logic [3:0] in_datak;
  logic in_active;
  logic in_boundary;
  logic in_ready;
  logic [31:0] out_data;
  logic [3:0] out_datak;
  logic out_active;
  modport master (output in_data, in_datak, in_active, in_boundary, input in_ready, out_data, out_datak, out_active);
  modport slave (input in_data, in_datak, in_active, in_boundary, output in_ready, out_data, out_datak, out_active);
endinterface

// File: rtl/usb3_scramble_tx_lfsr.sv
// usb3_lfsr: x^16+x^5+x^4+x^3+1 keystream, 32 bits/word; ports: local_clk, reset_n, scram_en (advance), scram_rst (reload), scram_init (seed), keystream (lane [31:24] first, bit 0 of each byte generated first)
module usb3_lfsr
  import usb3_scramble_tx_pkg::*;
(
  input  logic        local_clk,
  input  logic        reset_n,
  input  logic        scram_en,
  input  logic        scram_rst,
  input  logic [15:0] scram_init,
  output logic [31:0] keystream
);
  logic [15:0] state, nxt;
  always_comb begin
    nxt = state;
    keystream = '0;
    for (int i = 0; i < 32; i++) begin
      keystream[8*(3 - i/8) + i%8] = nxt[15];
      nxt = {nxt[14:0], 1'b0} ^ (nxt[15] ? LFSR_TAPS : 16'h0000);
    end
  end
  always_ff @(posedge local_clk) begin
    if (!reset_n || scram_rst) state <= scram_init;
    else if (scram_en) state <= nxt;
  end
endmodule

// File: rtl/usb3_scramble_tx.sv
// usb3_scramble_tx: USB 3.0 TX scrambler with idle fill and SKP insertion; ports: local_clk, reset_n (sync, low), enable, bus (slave: in_* upstream + in_ready, out_* to PIPE), err_skp_overflow (sticky)
module usb3_scramble_tx
  import usb3_scramble_tx_pkg::*;
#(
  parameter int SKP_PERIOD = SKP_PERIOD_DEF,
  parameter int SKP_OWED_MAX = SKP_OWED_MAX_DEF
) (
  input  logic local_clk,
  input  logic reset_n,
  input  logic enable,
  usb3_scramble_tx_if.slave bus,
  output logic err_skp_overflow
);
  localparam int OW = $clog2(SKP_OWED_MAX + 1);
  src_e src;
  logic insert, credit, owed_inc, scram_en;
  logic [8:0] sym_cnt, sym_sum;
  logic [OW-1:0] owed;
  logic [31:0] sel_data, s1_data, ks, ks_mask;
  logic [3:0] sel_datak, s1_datak;
  logic s1_valid, s1_skp, s1_active, s1_com;
  assign insert = owed >= OW'(2) && (!bus.in_active || bus.in_boundary);
  assign bus.in_ready = reset_n && !insert;
  // flushed stage-1 bubbles and SKP words must not consume keystream
  assign scram_en = s1_valid && !s1_skp;
  always_comb begin
    src = insert ? SRC_SKP : bus.in_active ? SRC_DATA : SRC_IDLE;
    sel_data = src == SRC_SKP ? SKP_WORD : src == SRC_DATA ? bus.in_data : '0;
    sel_datak = src == SRC_SKP ? 4'hF : src == SRC_DATA ? bus.in_datak : '0;
    sym_sum = sym_cnt + (src == SRC_SKP ? 9'd0 : 9'd4);
    credit = sym_sum >= 9'(SKP_PERIOD);
    // a credit arriving alongside an insertion still counts even at saturation (net -1)
    owed_inc = credit && (insert || owed != OW'(SKP_OWED_MAX));
    ks_mask = enable && scram_en ? ks & d_mask(s1_datak) : '0;
  end
  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      sym_cnt <= '0;
      owed <= '0;
      err_skp_overflow <= 1'b0;
      s1_valid <= 1'b0;
      s1_skp <= 1'b0;
      s1_active <= 1'b0;
      s1_com <= 1'b0;
      s1_data <= '0;
      s1_datak <= '0;
      bus.out_data <= '0;
      bus.out_datak <= '0;
      bus.out_active <= 1'b0;
    end else begin
      sym_cnt <= credit ? sym_sum - 9'(SKP_PERIOD) : sym_sum;
      owed <= owed + OW'(owed_inc) - (insert ? OW'(2) : OW'(0));
      err_skp_overflow <= err_skp_overflow || (credit && !owed_inc);
      s1_valid <= 1'b1;
      s1_skp <= src == SRC_SKP;
      s1_active <= src == SRC_DATA;
      s1_com <= has_com(sel_data, sel_datak);
      s1_data <= sel_data;
      s1_datak <= sel_datak;
      bus.out_data <= s1_data ^ ks_mask;
      bus.out_datak <= s1_datak;
      bus.out_active <= s1_active;
    end
  end
  usb3_lfsr u_lfsr (
    .local_clk(local_clk),
    .reset_n(reset_n),
    .scram_en(scram_en),
    .scram_rst(s1_com),
    .scram_init(LFSR_SEED),
    .keystream(ks)
  );
endmodule

// File: tb/tb_usb3_scramble_tx.sv
// tb_usb3_scramble_tx: cycle-level model comparison plus directed literal checks for usb3_scramble_tx
module tb_usb3_scramble_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic err;
  int total = 0;
  int bad = 0;
  usb3_scramble_tx_if bus();
  usb3_scramble_tx dut (
    .local_clk(clk),
    .reset_n(rst_n),
    .enable(enable),
    .bus(bus),
    .err_skp_overflow(err)
  );
  always #5 clk = ~clk;

  logic [7:0] ksb [8192];
  int m_owed, m_total, m_cred, m_idx;
  bit m_err, mon_on, exp_rdy;
  logic [31:0] p_data, p_ks, e_data;
  logic [3:0] p_k, e_k;
  bit p_v, p_skp, p_act, e_act;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  initial begin
    logic [15:0] r;
    bit ins, cr, com;
    r = 16'hFFFF;
    for (int b = 0; b < 8192; b++)
      for (int j = 0; j < 8; j++) begin
        ksb[b][j] = r[15];
        r = {r[14:0], 1'b0} ^ (r[15] ? 16'h0039 : 16'h0000);
      end
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mon_on = 1;
        m_owed = 0; m_total = 0; m_cred = 0; m_idx = 0; m_err = 0;
        p_v = 0; p_skp = 0; p_act = 0; p_data = 0; p_k = 0; p_ks = 0;
        e_data = 0; e_k = 0; e_act = 0;
      end else begin
        e_data = p_data; e_k = p_k; e_act = p_act;
        if (p_v && !p_skp && enable)
          for (int i = 0; i < 4; i++) if (!p_k[i]) e_data[8*i +: 8] = e_data[8*i +: 8] ^ p_ks[8*i +: 8];
        ins = m_owed >= 2 && (!bus.in_active || bus.in_boundary);
        cr = 0;
        p_v = 1;
        p_skp = ins;
        p_act = !ins && bus.in_active;
        p_data = ins ? 32'h3C3C3C3C : bus.in_active ? bus.in_data : 32'h0;
        p_k = ins ? 4'hF : bus.in_active ? bus.in_datak : 4'h0;
        p_ks = {ksb[m_idx], ksb[m_idx + 1], ksb[m_idx + 2], ksb[m_idx + 3]};
        if (!ins) begin
          com = 0;
          for (int i = 0; i < 4; i++) if (p_k[i] && p_data[8*i +: 8] == 8'hBC) com = 1;
          m_idx = com ? 0 : m_idx + 4;
          m_total += 4;
          if (m_total >= 354 * (m_cred + 1)) begin
            m_cred++;
            cr = 1;
          end
        end
        if (ins) m_owed -= 2;
        if (cr) begin
          if (m_owed < 8) m_owed++;
          else m_err = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      exp_rdy = rst_n && !(m_owed >= 2 && (!bus.in_active || bus.in_boundary));
      chk("cycle_model", {bus.out_data, bus.out_datak, bus.out_active, err, bus.in_ready},
          {e_data, e_k, e_act, m_err, exp_rdy});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_active = 0;
    bus.in_data = 0;
    bus.in_datak = 0;
  endtask

  task automatic drive(input int a);
    logic [31:0] v;
    v = a;
    bus.in_active = 1;
    bus.in_datak = (a % 7 == 3) ? 4'b0100 : 4'b0000;
    bus.in_data = {v[7:0] ^ 8'h5A, (a % 7 == 3) ? 8'h1C : v[7:0] + 8'h11, v[15:8] ^ 8'hA5, v[7:0] + 8'h33};
  endtask

  initial begin
    int acc, first_low, lows;
    logic [3:0] pat;
    idle();
    bus.in_boundary = 0;
    tick();
    tick();
    chk("reset_state", {bus.out_data, bus.out_datak, bus.out_active, err, bus.in_ready}, 0);
    rst_n = 1;
    #1;
    chk("ready_after_release", bus.in_ready, 1);
    tick();
    tick();
    chk("idle_seed_ks0", bus.out_data, 32'hFF17C014);
    tick();
    chk("idle_seed_ks1", bus.out_data, 32'hB2E70282);
    bus.in_active = 1;
    bus.in_data = 32'hBCBCBCBC;
    bus.in_datak = 4'hF;
    bus.in_boundary = 1;
    tick();
    idle();
    tick();
    chk("com_word_out", {bus.out_data, bus.out_datak, bus.out_active}, {32'hBCBCBCBC, 4'hF, 1'b1});
    tick();
    chk("after_com_ks0", {bus.out_data, bus.out_active}, {32'hFF17C014, 1'b0});
    tick();
    chk("after_com_ks1", bus.out_data, 32'hB2E70282);
    enable = 0;
    tick();
    chk("bypass_idle0", {bus.out_data, bus.out_datak, bus.out_active}, 0);
    tick();
    chk("bypass_idle1", {bus.out_data, bus.out_datak, bus.out_active}, 0);
    enable = 1;
    tick();
    tick();

    rst_n = 0;
    idle();
    tick();
    tick();
    rst_n = 1;
    bus.in_boundary = 1;
    acc = 0;
    first_low = -1;
    for (int c = 0; c < 400 && first_low < 0; c++) begin
      drive(acc);
      #1;
      if (bus.in_ready) acc++;
      else first_low = acc;
      tick();
    end
    chk("skp_after_177_words", first_low, 177);
    tick();
    chk("skp_word", {bus.out_data, bus.out_datak, bus.out_active}, {32'h3C3C3C3C, 4'hF, 1'b0});
    acc++;
    for (int c = 0; c < 20; c++) begin
      drive(acc);
      tick();
      acc++;
    end

    rst_n = 0;
    idle();
    bus.in_boundary = 0;
    tick();
    tick();
    rst_n = 1;
    acc = 0;
    lows = 0;
    for (int c = 0; c < 400; c++) begin
      drive(acc);
      #1;
      if (!bus.in_ready) lows++;
      else acc++;
      tick();
    end
    chk("no_skp_mid_packet", lows, 0);
    bus.in_boundary = 1;
    pat = 0;
    for (int c = 0; c < 4; c++) begin
      drive(acc);
      #1;
      pat = {pat[2:0], bus.in_ready};
      if (bus.in_ready) acc++;
      tick();
    end
    chk("two_skp_then_data", pat, 4'b0011);
    tick();
    tick();

    rst_n = 0;
    idle();
    bus.in_boundary = 0;
    tick();
    tick();
    rst_n = 1;
    for (int i = 1; i <= 900; i++) begin
      drive(i);
      tick();
      if (i == 796) chk("err_before_9th_credit", err, 0);
      if (i == 797) chk("err_at_9th_credit", err, 1);
    end
    chk("err_sticky", err, 1);
    rst_n = 0;
    tick();
    chk("reset_mid_packet", {bus.out_data, bus.out_datak, bus.out_active, err, bus.in_ready}, 0);
    rst_n = 1;
    idle();
    tick();
    tick();
    chk("restart_seed_ks0", bus.out_data, 32'hFF17C014);
    tick();
    chk("restart_seed_ks1", bus.out_data, 32'hB2E70282);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
